// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_signed_op(muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem(muldiv_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Combinational restoring-divider step retiring DIV_BITS quotient bits.
module div_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DIV_BITS = 1
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   r;
  logic [XLEN-1:0] q;

  // quo holds the remaining dividend bits (MSB first) and collects quotient bits at the LSB
  always_comb begin
    r = rem_i;
    q = quo_i;
    for (int i = 0; i < int'(DIV_BITS); i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, dvs_i}) begin
        r    = r - {1'b0, dvs_i};
        q[0] = 1'b1;
      end
    end
    rem_o = r;
    quo_o = q;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Handshaked M-extension multiply/divide unit: fast path for single-cycle mul and
// divide special cases, iterative path for division and the optional shift-add multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TAG_W         = 5,
  parameter int unsigned DIV_BITS      = 1,
  parameter int unsigned MUL_ITERATIVE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned STEPS = XLEN / DIV_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned PW    = 2 * XLEN + 2;
  localparam int unsigned PW2   = 2 * XLEN;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_t       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d, dvs_q, dvs_d;
  logic [PW2-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             valid_q, valid_d;

  muldiv_op_t       in_op_e;
  logic             accept, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag, fast_mul, fast_div;
  logic [PW-1:0]    pa, pb;
  logic [PW2-1:0]   prod, acc_nx, p_fin;
  logic [XLEN:0]    rem_nx;
  logic [XLEN-1:0]  quo_nx, q_fin, r_fin, calc_res;

  assign in_op_e    = muldiv_op_t'(in_op);
  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_tag    = tag_q;

  // Operand signedness and magnitudes, shared by both arithmetic paths
  assign a_sgn = (in_op_e == OP_MULH) || (in_op_e == OP_MULHSU) || is_signed_op(in_op_e);
  assign b_sgn = (in_op_e == OP_MULH) || is_signed_op(in_op_e);
  assign a_neg = a_sgn && in_rs1[XLEN-1];
  assign b_neg = b_sgn && in_rs2[XLEN-1];
  assign a_mag = a_neg ? -in_rs1 : in_rs1;
  assign b_mag = b_neg ? -in_rs2 : in_rs2;

  // Single-cycle product on XLEN+1-bit extended operands
  assign pa       = {{(PW-XLEN){a_neg}}, in_rs1};
  assign pb       = {{(PW-XLEN){b_neg}}, in_rs2};
  assign prod     = PW2'(pa * pb);
  assign fast_mul = (in_op_e == OP_MUL) ? prod[XLEN-1:0] : prod[PW2-1:XLEN];

  assign div_zero = (in_rs2 == '0);
  assign div_ovf  = is_signed_op(in_op_e) && (in_rs1 == XMIN) && (in_rs2 == '1);
  assign fast_div = is_rem(in_op_e) ? (div_zero ? in_rs1 : '0) : (div_zero ? '1 : XMIN);

  div_iter #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  // Shift-add step: quo_q doubles as the right-shifting multiplier
  assign acc_nx   = acc_q + mcand_q * PW2'(quo_q[DIV_BITS-1:0]);
  assign p_fin    = negq_q ? -acc_nx : acc_nx;
  assign q_fin    = negq_q ? -quo_nx : quo_nx;
  assign r_fin    = negr_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
  assign calc_res = is_div(op_q) ? (is_rem(op_q) ? r_fin : q_fin)
                  : ((op_q == OP_MUL) ? p_fin[XLEN-1:0] : p_fin[PW2-1:XLEN]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: ;
      S_CALC: begin
        cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        if (is_div(op_q)) begin
          rem_d = rem_nx;
          quo_d = quo_nx;
        end else begin
          acc_d   = acc_nx;
          mcand_d = mcand_q << DIV_BITS;
          quo_d   = quo_q >> DIV_BITS;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          res_d   = calc_res;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new op may start on the drain cycle of the previous one
    if (accept) begin
      op_d    = in_op_e;
      tag_d   = in_tag;
      negq_d  = a_neg ^ b_neg;
      negr_d  = a_neg;
      rem_d   = '0;
      quo_d   = is_div(in_op_e) ? a_mag : b_mag;
      dvs_d   = b_mag;
      acc_d   = '0;
      mcand_d = {{XLEN{1'b0}}, a_mag};
      if (is_div(in_op_e) && (div_zero || div_ovf)) begin
        state_d = S_DONE;
        res_d   = fast_div;
      end else if (!is_div(in_op_e) && (MUL_ITERATIVE == 0)) begin
        state_d = S_DONE;
        res_d   = fast_mul;
      end else begin
        state_d = S_CALC;
        cnt_d   = CNT_W'(STEPS);
      end
    end

    if (flush) state_d = S_IDLE;
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      tag_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: three configurations (32b radix-2, 32b radix-16, 64b iterative mul).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk, reset;
  logic [2:0]  flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [63:0] rs1, rs2;
  logic [4:0]  in_tag, tag0, tag1, tag2;
  logic [31:0] res0, res1;
  logic [63:0] res2;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5), .DIV_BITS(1), .MUL_ITERATIVE(0)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_op(in_op), .in_rs1(rs1[31:0]), .in_rs2(rs2[31:0]), .in_tag(in_tag),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(res0), .out_tag(tag0));

  muldiv_unit #(.XLEN(32), .TAG_W(5), .DIV_BITS(4), .MUL_ITERATIVE(0)) u_dut32r16 (
    .clk(clk), .reset(reset), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_op(in_op), .in_rs1(rs1[31:0]), .in_rs2(rs2[31:0]), .in_tag(in_tag),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(res1), .out_tag(tag1));

  muldiv_unit #(.XLEN(64), .TAG_W(5), .DIV_BITS(2), .MUL_ITERATIVE(1)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_op(in_op), .in_rs1(rs1), .in_rs2(rs2), .in_tag(in_tag),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_result(res2), .out_tag(tag2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] get_res(input int u);
    case (u)
      0:       return 64'(res0);
      1:       return 64'(res1);
      default: return res2;
    endcase
  endfunction

  function automatic logic [4:0] get_tag(input int u);
    case (u)
      0:       return tag0;
      1:       return tag1;
      default: return tag2;
    endcase
  endfunction

  // Latency counts rising edges from the accept edge (inclusive) to out_valid
  task automatic run_op(input int u, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tg, input logic [63:0] exp,
                        input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    in_op = op; rs1 = a; rs2 = b; in_tag = tg; in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    lat = 1;
    while (!out_valid[u] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_res"}, get_res(u), exp);
    check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    check({nm, "_tag"}, 64'(get_tag(u)), 64'(tg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    reset = 1'b1; flush = '0; in_valid = '0; out_ready = '1;
    in_op = '0; rs1 = '0; rs2 = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_res0", 64'(res0), 64'(0));
    check("rst_tag0", 64'(tag0), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(3'b111));
    reset = 1'b0;

    // 32-bit, single-cycle multiplier
    run_op(0, OP_MULH,   64'h8000_0000, 64'h8000_0000, 5'd1, 64'h4000_0000, 1, "mulh");
    run_op(0, OP_MULHSU, '1, 64'hFFFF_FFFF, 5'd2, 64'hFFFF_FFFF, 1, "mulhsu");
    run_op(0, OP_MUL,    64'd7, 64'd6, 5'd3, 64'd42, 1, "mul");
    run_op(0, OP_MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd4, 64'hFFFF_FFFE, 1, "mulhu");

    // 32-bit divider, radix 2
    run_op(0, OP_DIV,  -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFD, 33, "div_neg");
    run_op(0, OP_REM,  -64'sd7, 64'd2, 5'd6, 64'hFFFF_FFFF, 33, "rem_neg");
    run_op(0, OP_DIVU, 64'd100, 64'd7, 5'd7, 64'd14, 33, "divu");
    run_op(0, OP_REMU, 64'd100, 64'd7, 5'd8, 64'd2, 33, "remu");

    // Divide special cases
    run_op(0, OP_DIVU, 64'd5, 64'd0, 5'd9, 64'hFFFF_FFFF, 1, "divu_z");
    run_op(0, OP_REMU, 64'h1234, 64'd0, 5'd10, 64'h1234, 1, "remu_z");
    run_op(0, OP_DIV,  -64'sd7, 64'd0, 5'd11, 64'hFFFF_FFFF, 1, "div_z");
    run_op(0, OP_REM,  -64'sd7, 64'd0, 5'd12, 64'hFFFF_FFF9, 1, "rem_z");
    run_op(0, OP_DIV,  64'h8000_0000, '1, 5'd13, 64'h8000_0000, 1, "div_ovf");
    run_op(0, OP_REM,  64'h8000_0000, '1, 5'd14, 64'd0, 1, "rem_ovf");

    // 32-bit divider, radix 16
    run_op(1, OP_DIV, -64'sd7, 64'd2, 5'd15, 64'hFFFF_FFFD, 9, "r16_div");
    run_op(1, OP_DIV, 64'd100, -64'sd7, 5'd16, 64'hFFFF_FFF2, 9, "r16_div_nd");
    run_op(1, OP_REM, 64'd100, -64'sd7, 5'd17, 64'd2, 9, "r16_rem_nd");

    // Backpressure then drain-and-accept on the same edge
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_op = OP_MUL; rs1 = 64'd3; rs2 = 64'd5; in_tag = 5'd9; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("hold_first", 64'(out_valid[0]), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid[0]), 64'(1));
      check("hold_res", 64'(res0), 64'd15);
      check("hold_tag", 64'(tag0), 64'd9);
      check("hold_inrdy", 64'(in_ready[0]), 64'(0));
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_op = OP_MUL; rs1 = 64'd2; rs2 = 64'd3; in_tag = 5'd4; in_valid[0] = 1'b1;
    #1 check("b2b_inrdy", 64'(in_ready[0]), 64'(1));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("b2b_valid", 64'(out_valid[0]), 64'(1));
    check("b2b_res", 64'(res0), 64'd6);
    check("b2b_tag", 64'(tag0), 64'd4);

    // Flush at iteration 10 of a divide, with a competing request in the same cycle
    @(negedge clk);
    in_op = OP_DIV; rs1 = 64'd1000; rs2 = 64'd3; in_tag = 5'd3; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    check("flush_valid", 64'(out_valid[0]), 64'(0));
    check("flush_inrdy", 64'(in_ready[0]), 64'(1));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    check("flush_never_valid", 64'(seen), 64'(0));

    // Asynchronous reset in the middle of an iterative divide
    @(negedge clk);
    in_op = OP_DIV; rs1 = 64'd100; rs2 = 64'd7; in_tag = 5'd17; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid[0]), 64'(0));
    check("arst_res", 64'(res0), 64'(0));
    check("arst_tag", 64'(tag0), 64'(0));
    check("arst_inrdy", 64'(in_ready[0]), 64'(1));
    @(negedge clk);
    reset = 1'b0;

    // 64-bit, iterative multiplier and radix-4 divider
    run_op(2, OP_MUL,    64'h1_0000_0001, 64'd3, 5'd20, 64'h3_0000_0003, 33, "m64_mul");
    run_op(2, OP_MULH,   64'h8000_0000_0000_0000, 64'd2, 5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 33, "m64_mulh");
    run_op(2, OP_MULHU,  '1, '1, 5'd22, 64'hFFFF_FFFF_FFFF_FFFE, 33, "m64_mulhu");
    run_op(2, OP_MULHSU, '1, '1, 5'd23, 64'hFFFF_FFFF_FFFF_FFFF, 33, "m64_mulhsu");
    run_op(2, OP_DIV,    -64'sd100, 64'd7, 5'd24, 64'hFFFF_FFFF_FFFF_FFF2, 33, "m64_div");
    run_op(2, OP_REM,    -64'sd100, 64'd7, 5'd25, 64'hFFFF_FFFF_FFFF_FFFE, 33, "m64_rem");
    run_op(2, OP_DIVU,   64'h8000_0000_0000_0000, 64'd3, 5'd26, 64'h2AAA_AAAA_AAAA_AAAA, 33, "m64_divu");
    run_op(2, OP_REMU,   64'h8000_0000_0000_0000, 64'd3, 5'd27, 64'd2, 33, "m64_remu");
    run_op(2, OP_DIV,    64'h8000_0000_0000_0000, '1, 5'd28, 64'h8000_0000_0000_0000, 1, "m64_ovf");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
